// File: rtl/uart_tx_queue.sv
// Byte queue feeding a UART transmitter: buffers host writes and launches them one at a time.
// Define UART_TXQ_OVF_EN to add the sticky overflow flag (ovf) and its clear input (ovf_clr).
module uart_tx_queue #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              tx_en,
    output logic [7:0]        tx_data,
    input  logic              tx_busy,
    input  logic              tx_done
`ifdef UART_TXQ_OVF_EN
    ,
    output logic              ovf,
    input  logic              ovf_clr
`endif
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               full_q, full_d;
    logic               empty_q, empty_d;
    logic               tx_en_q, tx_en_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               wr_accept_c;
    logic               pop_c;
    logic [7:0]         mem_q [0:DEPTH-1];

    // Launch sequencer: one byte per transmitter frame.
    always_comb begin
        state_d = state_q;
        pop_c   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty_q && !tx_busy) begin
                    pop_c   = 1'b1;
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (tx_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        tx_en_d = (state_d == ST_LAUNCH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Pointer, occupancy and launch-data next values; a write to a full queue is dropped outright.
    always_comb begin
        wr_accept_c = wr_en && !full_q;
        wr_ptr_d    = wr_accept_c ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
        rd_ptr_d    = pop_c ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
        tx_data_d   = pop_c ? mem_q[rd_ptr_q] : tx_data_q;
        count_d     = count_q;
        case ({wr_accept_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == DEPTH_CNT);
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            tx_en_q   <= 1'b0;
            tx_data_q <= 8'h00;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            tx_en_q   <= tx_en_d;
            tx_data_q <= tx_data_d;
        end
    end

    // Storage array keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (wr_accept_c) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

`ifdef UART_TXQ_OVF_EN
    logic ovf_q, ovf_d;

    // A drop wins over a same-cycle clear.
    always_comb begin
        ovf_d = (wr_en && full_q) || (ovf_q && !ovf_clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

    assign full    = full_q;
    assign empty   = empty_q;
    assign count   = count_q;
    assign tx_en   = tx_en_q;
    assign tx_data = tx_data_q;

endmodule
